// File: rtl/wb_bridge_pkg.sv
// Shared types and constants for the Caravel user-project Wishbone bridge:
// FSM states, slave select, region bases and CSR page offsets.
package wb_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_RESP
   } state_e;

   typedef enum logic [1:0] {
      SEL_S0,
      SEL_S1,
      SEL_CSR,
      SEL_NONE
   } slv_sel_e;

   localparam logic [31:0] DEF_NEURO_BASE  = 32'h3000_0000;
   localparam logic [31:0] DEF_MATMUL_BASE = 32'h3100_0000;
   localparam logic [31:0] DEF_CSR_BASE    = 32'h3200_0000;
   localparam logic [31:0] DEF_REGION_MASK = 32'hFFFF_F000;
   localparam logic [31:0] DEF_ERR_DATA    = 32'hDEAD_BEEF;

   localparam logic [31:0] CSR_STATUS_OFF   = 32'h0000_0000;
   localparam logic [31:0] CSR_LAST_ERR_OFF = 32'h0000_0004;

   function automatic slv_sel_e decode_region(input logic [31:0] adr,
                                              input logic [31:0] s0_base,
                                              input logic [31:0] s1_base,
                                              input logic [31:0] csr_base,
                                              input logic [31:0] mask);
      logic [31:0] region;
      region = adr & mask;
      if (region == (s0_base & mask))  return SEL_S0;
      if (region == (s1_base & mask))  return SEL_S1;
      if (region == (csr_base & mask)) return SEL_CSR;
      return SEL_NONE;
   endfunction

endpackage

// File: rtl/wb_bridge_csr.sv
// Error bookkeeping for the bridge: saturating error count, sticky flag,
// last-error type and address, plus the local CSR read mux.
module wb_bridge_csr
   import wb_bridge_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        log_i,
   input  logic        log_tmo_i,
   input  logic [31:0] log_addr_i,
   input  logic        wr_i,
   input  logic        wdat0_i,
   input  logic [31:0] off_i,
   output logic [31:0] rdata_o,
   output logic        flag_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             flag_q, flag_d;
   logic             tmo_q, tmo_d;
   logic [31:0]      last_q, last_d;
   logic [15:0]      cnt_ext;

   always_comb begin
      cnt_d  = cnt_q;
      flag_d = flag_q;
      tmo_d  = tmo_q;
      last_d = last_q;
      if (wr_i && wdat0_i && (off_i == CSR_STATUS_OFF)) begin
         cnt_d  = '0;
         flag_d = 1'b0;
         tmo_d  = 1'b0;
      end
      // A log and a clear never share a cycle; log is applied last regardless.
      if (log_i) begin
         if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
         flag_d = 1'b1;
         tmo_d  = log_tmo_i;
         last_d = log_addr_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         flag_q <= 1'b0;
         tmo_q  <= 1'b0;
         last_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         flag_q <= flag_d;
         tmo_q  <= tmo_d;
         last_q <= last_d;
      end
   end

   always_comb begin
      cnt_ext              = '0;
      cnt_ext[CNT_W-1:0]   = cnt_q;
   end

   always_comb begin
      rdata_o = '0;
      case (off_i)
         CSR_STATUS_OFF:   rdata_o = {cnt_ext, 14'd0, tmo_q, flag_q};
         CSR_LAST_ERR_OFF: rdata_o = last_q;
         default:          rdata_o = '0;
      endcase
   end

   assign flag_o = flag_q;

endmodule

// File: rtl/wb_slave_bridge.sv
// Registered Wishbone bridge: decodes one master cycle at a time onto the
// neuromorphic slave, the matmul slave or the local CSR page, with timeout.
module wb_slave_bridge
   import wb_bridge_pkg::*;
#(
   parameter logic [31:0] NEURO_BASE     = DEF_NEURO_BASE,
   parameter logic [31:0] MATMUL_BASE    = DEF_MATMUL_BASE,
   parameter logic [31:0] CSR_BASE       = DEF_CSR_BASE,
   parameter logic [31:0] REGION_MASK    = DEF_REGION_MASK,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_DATA       = DEF_ERR_DATA,
   parameter int unsigned ERR_CNT_W      = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        s0_cyc_o,
   output logic        s0_stb_o,
   output logic        s0_we_o,
   output logic [3:0]  s0_sel_o,
   output logic [31:0] s0_adr_o,
   output logic [31:0] s0_dat_o,
   input  logic        s0_ack_i,
   input  logic [31:0] s0_dat_i,
   output logic        s1_cyc_o,
   output logic        s1_stb_o,
   output logic        s1_we_o,
   output logic [3:0]  s1_sel_o,
   output logic [31:0] s1_adr_o,
   output logic [31:0] s1_dat_o,
   input  logic        s1_ack_i,
   input  logic [31:0] s1_dat_i,
   output logic        err_irq_o
);

   localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

   state_e      state_q, state_d;
   slv_sel_e    slv_q, slv_d, dec;
   logic [31:0] adr_q, adr_d, wdat_q, wdat_d, rdat_q, rdat_d;
   logic        we_q, we_d;
   logic [3:0]  bsel_q, bsel_d;
   logic [15:0] tmo_q, tmo_d, tmo_inc;
   logic        err_log, err_tmo, csr_wr;
   logic [31:0] err_addr, csr_off, csr_rdata;
   logic        slv_ack, s0_act, s1_act;
   logic [31:0] slv_dat;

   assign dec     = decode_region(wbs_adr_i, NEURO_BASE, MATMUL_BASE, CSR_BASE, REGION_MASK);
   assign csr_off = wbs_adr_i & ~REGION_MASK;
   assign tmo_inc = tmo_q + 16'd1;
   assign slv_ack = (slv_q == SEL_S1) ? s1_ack_i : s0_ack_i;
   assign slv_dat = (slv_q == SEL_S1) ? s1_dat_i : s0_dat_i;

   always_comb begin
      state_d  = state_q;
      slv_d    = slv_q;
      adr_d    = adr_q;
      we_d     = we_q;
      bsel_d   = bsel_q;
      wdat_d   = wdat_q;
      rdat_d   = rdat_q;
      tmo_d    = tmo_q;
      err_log  = 1'b0;
      err_tmo  = 1'b0;
      err_addr = adr_q;
      csr_wr   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (wbs_cyc_i && wbs_stb_i) begin
               adr_d  = wbs_adr_i;
               we_d   = wbs_we_i;
               bsel_d = wbs_sel_i;
               wdat_d = wbs_dat_i;
               slv_d  = dec;
               case (dec)
                  SEL_S0, SEL_S1: begin
                     state_d = ST_ACTIVE;
                     tmo_d   = '0;
                  end
                  SEL_CSR: begin
                     state_d = ST_RESP;
                     rdat_d  = csr_rdata;
                     csr_wr  = wbs_we_i;
                  end
                  default: begin
                     state_d  = ST_RESP;
                     rdat_d   = wbs_we_i ? 32'h0 : ERR_DATA;
                     err_log  = 1'b1;
                     err_addr = wbs_adr_i;
                  end
               endcase
            end
         end
         ST_ACTIVE: begin
            // Master abort beats everything; a slave ack beats the timeout.
            if (!wbs_cyc_i) begin
               state_d = ST_IDLE;
            end else if (slv_ack) begin
               state_d = ST_RESP;
               rdat_d  = slv_dat;
            end else if (tmo_inc == TMO_LIMIT) begin
               state_d = ST_RESP;
               rdat_d  = we_q ? 32'h0 : ERR_DATA;
               err_log = 1'b1;
               err_tmo = 1'b1;
            end else begin
               tmo_d = tmo_inc;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= ST_IDLE;
         slv_q   <= SEL_NONE;
         adr_q   <= '0;
         we_q    <= 1'b0;
         bsel_q  <= '0;
         wdat_q  <= '0;
         rdat_q  <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         slv_q   <= slv_d;
         adr_q   <= adr_d;
         we_q    <= we_d;
         bsel_q  <= bsel_d;
         wdat_q  <= wdat_d;
         rdat_q  <= rdat_d;
         tmo_q   <= tmo_d;
      end
   end

   wb_bridge_csr #(.CNT_W(ERR_CNT_W)) u_csr (
      .clk        (wb_clk_i),
      .rst_n      (wb_rst_ni),
      .log_i      (err_log),
      .log_tmo_i  (err_tmo),
      .log_addr_i (err_addr),
      .wr_i       (csr_wr),
      .wdat0_i    (wbs_dat_i[0]),
      .off_i      (csr_off),
      .rdata_o    (csr_rdata),
      .flag_o     (err_irq_o)
   );

   // Idle slave buses are held at zero so nothing leaks to an unselected slave.
   assign s0_act   = (state_q == ST_ACTIVE) && (slv_q == SEL_S0);
   assign s1_act   = (state_q == ST_ACTIVE) && (slv_q == SEL_S1);

   assign s0_cyc_o = s0_act;
   assign s0_stb_o = s0_act;
   assign s0_we_o  = s0_act & we_q;
   assign s0_sel_o = s0_act ? bsel_q : 4'h0;
   assign s0_adr_o = s0_act ? adr_q : 32'h0;
   assign s0_dat_o = s0_act ? wdat_q : 32'h0;

   assign s1_cyc_o = s1_act;
   assign s1_stb_o = s1_act;
   assign s1_we_o  = s1_act & we_q;
   assign s1_sel_o = s1_act ? bsel_q : 4'h0;
   assign s1_adr_o = s1_act ? adr_q : 32'h0;
   assign s1_dat_o = s1_act ? wdat_q : 32'h0;

   assign wbs_ack_o = (state_q == ST_RESP);
   assign wbs_dat_o = rdat_q;

endmodule
